// File: rtl/ftdi_receiver_if.sv
// Consumer-side handshake of the FTDI serial receiver: received byte, valid/ack
// pair and the two error indications.
interface ftdi_receiver_if;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       framing_error;
  logic       overrun;

  modport master (
    output data,
    output valid,
    output framing_error,
    output overrun,
    input  ack
  );

  modport slave (
    input  data,
    input  valid,
    input  framing_error,
    input  overrun,
    output ack
  );
endinterface

// File: rtl/ftdi_receiver.sv
// 8N1 UART receiver for an FTDI bridge: 16x oversampling, one-byte holding
// register with valid/ack handshake, framing-error pulse and sticky overrun.
module ftdi_receiver #(
  parameter int unsigned FREQUENCY  = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FTDI_TX,
  output logic             FTDI_RTS,
  output logic             busy,
  output logic [1:0]       state_test,
  ftdi_receiver_if.master  bus
);

  localparam int unsigned TICK_DIV = FREQUENCY / (BAUD_RATE * 16);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  logic [1:0]    r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic          r_rx_prev;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_samp_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_stop_hold;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_overrun;

  logic          w_tick;
  logic          w_fall;

  assign w_tick = (r_state != IDLE) && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_fall = r_rx_prev && !r_rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_tick_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stop_hold <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1   <= FTDI_TX;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
      r_ferr    <= 1'b0;

      if (r_state == IDLE || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + 1'b1;

      if (bus.ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state     <= START;
            r_samp_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_stop_hold <= 1'b0;
          end
        end
        START: begin
          // Re-check the line half a bit in; a high level means a glitch.
          if (w_tick) begin
            if (r_samp_cnt == 4'd7) begin
              if (!r_rx_s) begin
                r_state    <= DATA;
                r_samp_cnt <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
            if (r_samp_cnt == 4'd15) begin
              r_shift   <= {r_rx_s, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7)
                r_state <= STOP;
            end
          end
        end
        STOP: begin
          // After a bad stop bit, wait for the line to recover before re-arming.
          if (r_stop_hold) begin
            if (r_rx_s) begin
              r_state     <= IDLE;
              r_stop_hold <= 1'b0;
            end
          end else if (w_tick) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
            if (r_samp_cnt == 4'd15) begin
              if (r_rx_s) begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_overrun <= bus.ack ? 1'b0 : (r_overrun | r_valid);
                r_state   <= IDLE;
              end else begin
                r_ferr      <= 1'b1;
                r_stop_hold <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data          = r_data;
  assign bus.valid         = r_valid;
  assign bus.framing_error = r_ferr;
  assign bus.overrun       = r_overrun;
  assign FTDI_RTS          = ~r_valid;
  assign busy              = (r_state != IDLE);
  assign state_test        = r_state;

endmodule

// File: tb/tb_ftdi_receiver.sv
// Directed bench for ftdi_receiver at TICK_DIV=1 (16 clocks per bit).
module tb_ftdi_receiver;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       FTDI_TX = 1'b1;
  logic       FTDI_RTS;
  logic       busy;
  logic [1:0] state_test;

  ftdi_receiver_if bus ();

  ftdi_receiver #(
    .FREQUENCY (160),
    .BAUD_RATE (10),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .FTDI_TX   (FTDI_TX),
    .FTDI_RTS  (FTDI_RTS),
    .busy      (busy),
    .state_test(state_test),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  int ferr_cnt  = 0;
  int ferr_snap;
  int lat;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid && !valid_q) rise_cyc <= cyc;
    valid_q <= bus.valid;
    if (bus.framing_error) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 10-bit frame, 16 clocks per bit; ack pulses on the clock edge that
  // follows loop index ack_at (edge 155 after the start bit is the byte load).
  task automatic send(input logic [7:0] b, input logic stop, input int ack_at);
    int k;
    for (int i = 0; i < 160; i++) begin
      k = i / 16;
      if (k == 0)      FTDI_TX = 1'b0;
      else if (k <= 8) FTDI_TX = b[k-1];
      else             FTDI_TX = stop;
      bus.ack = (i == ack_at);
      if (i == 0) start_cyc = cyc;
      @(negedge clk);
    end
    bus.ack = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_test), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'h00);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rts", 32'(FTDI_RTS), 32'd1);
    chk("rst_ferr", 32'(bus.framing_error), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8'hA5, good stop bit
    send(8'hA5, 1'b1, -1);
    lat = rise_cyc - start_cyc;
    chk("a5_latency_in_154_156", 32'(lat >= 154 && lat <= 156), 32'd1);
    chk("a5_data", 32'(bus.data), 32'hA5);
    chk("a5_valid", 32'(bus.valid), 32'd1);
    chk("a5_rts", 32'(FTDI_RTS), 32'd0);
    do_ack();
    chk("a5_ack_valid", 32'(bus.valid), 32'd0);
    chk("a5_ack_rts", 32'(FTDI_RTS), 32'd1);

    // 4-clock low glitch
    ferr_snap = ferr_cnt;
    FTDI_TX = 1'b0;
    repeat (4) @(negedge clk);
    FTDI_TX = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_in_start", 32'(state_test), 32'd1);
    repeat (10) @(negedge clk);
    chk("glitch_idle", 32'(state_test), 32'd0);
    chk("glitch_valid", 32'(bus.valid), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt), 32'(ferr_snap));

    // 8'h3C with stop bit low, line held low afterwards
    ferr_snap = ferr_cnt;
    send(8'h3C, 1'b0, -1);
    repeat (10) @(negedge clk);
    chk("ferr_one_pulse", 32'(ferr_cnt - ferr_snap), 32'd1);
    chk("ferr_state_stop", 32'(state_test), 32'd3);
    chk("ferr_valid", 32'(bus.valid), 32'd0);
    FTDI_TX = 1'b1;
    repeat (4) @(negedge clk);
    chk("ferr_back_idle", 32'(state_test), 32'd0);

    // 8'h11 then 8'h22 without ack
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    chk("ovr_data", 32'(bus.data), 32'h22);
    chk("ovr_valid", 32'(bus.valid), 32'd1);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    do_ack();
    chk("ovr_ack_valid", 32'(bus.valid), 32'd0);
    chk("ovr_ack_flag", 32'(bus.overrun), 32'd0);

    // ack landing on the same edge as the next byte load
    send(8'h5A, 1'b1, -1);
    send(8'hC3, 1'b1, 154);
    chk("ackload_data", 32'(bus.data), 32'hC3);
    chk("ackload_valid", 32'(bus.valid), 32'd1);
    chk("ackload_no_ovr", 32'(bus.overrun), 32'd0);
    do_ack();

    // reset during data bit 4 of 8'hFF
    ferr_snap = ferr_cnt;
    FTDI_TX = 1'b0;
    repeat (16) @(negedge clk);
    FTDI_TX = 1'b1;
    repeat (72) @(negedge clk);
    chk("mid_in_data", 32'(state_test), 32'd2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_state", 32'(state_test), 32'd0);
    chk("mid_rst_data", 32'(bus.data), 32'h00);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    chk("mid_no_byte", 32'(bus.valid), 32'd0);
    send(8'h0F, 1'b1, -1);
    chk("mid_data", 32'(bus.data), 32'h0F);
    chk("mid_valid", 32'(bus.valid), 32'd1);
    chk("mid_no_ovr", 32'(bus.overrun), 32'd0);
    chk("mid_no_ferr", 32'(ferr_cnt), 32'(ferr_snap));
    do_ack();

    // back-to-back 8'h00 and 8'hFF, ack each
    send(8'h00, 1'b1, -1);
    chk("b2b_data0", 32'(bus.data), 32'h00);
    chk("b2b_valid0", 32'(bus.valid), 32'd1);
    do_ack();
    send(8'hFF, 1'b1, -1);
    chk("b2b_data1", 32'(bus.data), 32'hFF);
    chk("b2b_valid1", 32'(bus.valid), 32'd1);
    chk("b2b_no_ovr", 32'(bus.overrun), 32'd0);
    do_ack();
    chk("b2b_idle_rts", 32'(FTDI_RTS), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ftdi_receiver.md
FTDI_RECEIVER -- requirements
Module: ftdi_receiver

Interface
REQ-001 Parameter FREQUENCY, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; fixed at 16.
REQ-004 Derived TICK_DIV = FREQUENCY / (BAUD_RATE*16), integer floor, SHALL be >= 1 (27 at defaults).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 FTDI_TX  input  1  asynchronous serial line from FTDI, idle high.
REQ-008 data  output  8  last received byte.
REQ-009 valid  output  1  data holds an unread byte.
REQ-010 ack  input  1  consumer has taken data.
REQ-011 framing_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 overrun  output  1  sticky; a byte was overwritten before ack.
REQ-013 FTDI_RTS  output  1  high when receiver can accept a byte (valid low).
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 state_test  output  2  current FSM state encoding.

Function
REQ-016 FTDI_TX SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-017 Tick generator: counter 0..TICK_DIV-1, tick pulses one cycle on wrap; counter held at 0 in IDLE.
REQ-018 States: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11; state_test SHALL equal the state.
REQ-019 IDLE -> START on rx_s high-to-low transition; tick and sample counters clear.
REQ-020 START: on 8th tick sample rx_s; low -> DATA with sample counter cleared; high -> IDLE (glitch rejected, no outputs change).
REQ-021 DATA: sample rx_s every 16th tick (mid-bit); shift in LSB first; after 8th bit -> STOP.
REQ-022 STOP: on 16th tick sample rx_s.
REQ-023 Stop high: next cycle data <= shifted byte, valid <= 1; if valid was already 1 and ack not asserted that cycle, overrun <= 1; state -> IDLE.
REQ-024 Stop low: framing_error pulses one cycle, data/valid unchanged, state stays STOP until rx_s high, then IDLE.
REQ-025 ack while valid=1 clears valid and overrun next cycle; ack while valid=0 ignored.
REQ-026 ack in the same cycle a new byte loads: new byte loaded, valid stays 1, overrun not set.
REQ-027 FTDI_RTS SHALL equal ~valid, combinational.
REQ-028 Latency: valid rises 2 (sync) + (8+16*9)*TICK_DIV + 1 cycles after the FTDI_TX falling edge, +/-1 cycle.
REQ-029 Sample counter 4 bits, bit counter 3 bits; both wrap naturally, no saturation.

Reset
REQ-030 With reset low at a clk edge: state IDLE, data 8'h00, valid 0, overrun 0, framing_error 0, busy 0, counters 0, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abort the frame with no output change other than the REQ-030 values; the next falling edge after release starts a new frame.

Verification (FREQUENCY=160, BAUD_RATE=10, TICK_DIV=1, 16 clk/bit)
REQ-032 Send 8'hA5 with stop high -> valid=1, data=8'hA5 at cycle 155+/-1 after start edge, FTDI_RTS=0; ack -> valid=0, FTDI_RTS=1.
REQ-033 Low glitch of 4 clk on idle line -> returns to IDLE at START sample, valid stays 0, no framing_error.
REQ-034 Send 8'h3C with stop bit low -> one-cycle framing_error, valid stays 0, state holds STOP until line high.
REQ-035 Send 8'h11 then 8'h22 without ack -> data=8'h22, valid=1, overrun=1; ack clears both.
REQ-036 Assert reset during DATA bit 4 of 8'hFF, release, send 8'h0F -> only 8'h0F received, no error flags.
REQ-037 Back-to-back 8'h00 and 8'hFF with ack each -> both bytes correct, overrun stays 0.
